// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU issue sequencer.
package alu_seq_pkg;
    localparam int SEQ_BUS_W = 8;
    localparam int SEQ_ADDR_W = 3;
    typedef enum logic [2:0] {S_IDLE, S_LD1, S_LD2, S_EXEC, S_WB} seq_state_t;
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [4:0] REN_PHASE1 = 5'b00011;
    localparam logic [4:0] REN_PHASE2 = 5'b11100;
    typedef struct packed {
        logic f_add;
        logic f_load;
        logic keep;
        logic [SEQ_ADDR_W-1:0] ra;
        logic [SEQ_ADDR_W-1:0] rb;
        logic [SEQ_ADDR_W-1:0] rd;
        logic [SEQ_BUS_W-1:0] imm;
    } dec_instr_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: instruction handshake plus ALU/register-file control bundle.
interface alu_seq_if #(parameter int BUS_WIDTH = 8, parameter int REG_ADDR_W = 3);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [2:0]            instr_op;
    logic [REG_ADDR_W-1:0] instr_ra;
    logic [REG_ADDR_W-1:0] instr_rb;
    logic [REG_ADDR_W-1:0] instr_rd;
    logic [BUS_WIDTH-1:0]  instr_imm;
    logic [REG_ADDR_W-1:0] rd_addr_a;
    logic [REG_ADDR_W-1:0] rd_addr_b;
    logic [4:0]            reg_en;
    logic                  f_add;
    logic                  f_load;
    logic [BUS_WIDTH-1:0]  imm;
    logic [BUS_WIDTH-1:0]  result;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [BUS_WIDTH-1:0]  wb_data;
    logic                  busy;
    modport master (
        output instr_valid, instr_op, instr_ra, instr_rb, instr_rd, instr_imm, result,
        input  instr_ready, rd_addr_a, rd_addr_b, reg_en, f_add, f_load, imm,
               wb_en, wb_addr, wb_data, busy
    );
    modport slave (
        input  instr_valid, instr_op, instr_ra, instr_rb, instr_rd, instr_imm, result,
        output instr_ready, rd_addr_a, rd_addr_b, reg_en, f_add, f_load, imm,
               wb_en, wb_addr, wb_data, busy
    );
endinterface

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational opcode decode into the latched instruction struct.
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int BUS_WIDTH  = SEQ_BUS_W,
    parameter int REG_ADDR_W = SEQ_ADDR_W
) (
    input  logic [2:0]            op,
    input  logic [REG_ADDR_W-1:0] ra,
    input  logic [REG_ADDR_W-1:0] rb,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [BUS_WIDTH-1:0]  imm,
    output dec_instr_t            dec,
    output logic                  nop
);
    assign nop = op == OP_NOP;
    assign dec = '{f_add: op[0], f_load: op[1], keep: op[2], ra: ra, rb: rb, rd: rd, imm: imm};
endmodule

// File: rtl/alu_seq.sv
// alu_seq: issue-side sequencer driving ALU load strobes, mux selects and writeback.
// Optional ALU_SEQ_OVERLAP_EN lets a new instruction be accepted during WB.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int BUS_WIDTH  = SEQ_BUS_W,
    parameter int REG_ADDR_W = SEQ_ADDR_W
) (
    input logic    clk,
    input logic    rst,
    alu_seq_if.slave bus
);
    seq_state_t state, nxt, s;
    dec_instr_t dec, ins;
    logic nop, take, ld, ready_st;
    logic [BUS_WIDTH-1:0] wb_data_q;

    alu_seq_decode #(.BUS_WIDTH(BUS_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_dec (
        .op(bus.instr_op), .ra(bus.instr_ra), .rb(bus.instr_rb), .rd(bus.instr_rd),
        .imm(bus.instr_imm), .dec(dec), .nop(nop)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ins <= '0;
            wb_data_q <= '0;
        end else begin
            if (take) ins <= dec;
            if (state == S_EXEC) wb_data_q <= bus.result;
        end
    end

`ifdef ALU_SEQ_OVERLAP_EN
    assign ready_st = state == S_IDLE || state == S_WB;
`else
    assign ready_st = state == S_IDLE;
`endif
    assign take = bus.instr_valid && bus.instr_ready;

    always_comb begin
        nxt = state == S_LD1  ? S_LD2  :
              state == S_LD2  ? S_EXEC :
              state == S_EXEC ? S_WB   :
              (!take || nop)  ? S_IDLE :
              dec.keep        ? S_LD2  : S_LD1;
    end

    // While reset is held the outputs already look like IDLE, so an interrupted
    // instruction emits no further strobes.
    always_comb begin
        s = rst ? S_IDLE : state;
        ld = s == S_LD1 || s == S_LD2 || s == S_EXEC;
        bus.instr_ready = !rst && ready_st;
        bus.rd_addr_a = (s == S_LD1 || s == S_LD2) ? ins.ra : '0;
        bus.rd_addr_b = s == S_LD2 ? ins.rb : '0;
        bus.reg_en = (s == S_LD1 && !ins.keep) ? REN_PHASE1 : s == S_LD2 ? REN_PHASE2 : '0;
        bus.f_add = ld && ins.f_add;
        bus.f_load = ld && ins.f_load;
        bus.imm = ld ? ins.imm : '0;
        bus.wb_en = s == S_WB;
        bus.wb_addr = s == S_WB ? ins.rd : '0;
        bus.wb_data = wb_data_q;
        bus.busy = s != S_IDLE;
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq; expected phases and writebacks are queued
// at issue time and a negedge monitor pops them as the sequencer presents them.
module tb_alu_seq;
`ifdef ALU_SEQ_OVERLAP_EN
    localparam int GAP = 0;
`else
    localparam int GAP = 1;
`endif
    typedef struct {
        int c;
        logic [4:0] ren;
        logic fa;
        logic fl;
        logic [7:0] im;
        logic [2:0] ra;
        logic [2:0] rb;
    } stb_t;
    typedef struct {
        int c;
        logic [2:0] addr;
        logic [7:0] data;
    } wb_t;

    logic clk = 0;
    logic rst = 1;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int acc_q[$];
    stb_t stb_q[$];
    wb_t wbq[$];
    stb_t se;
    wb_t we;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_if bus();
    alu_seq dut(.clk(clk), .rst(rst), .bus(bus));

    // ALU stand-in: the pending instruction's result appears only during EXEC.
    always @* bus.result = (bus.busy && !bus.wb_en && bus.reg_en == 5'd0 && wbq.size() > 0) ? wbq[0].data : 8'hEE;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int exp_instr(input int t, input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                                     input logic [2:0] rd, input logic [7:0] im, input logic [7:0] res);
        int c;
        acc_q.push_back(t);
        if (op == 3'd0) return t + 1;
        c = t + 1;
        if (!op[2]) begin
            stb_q.push_back('{c, 5'b00011, op[0], op[1], im, ra, 3'd0});
            c++;
        end
        stb_q.push_back('{c, 5'b11100, op[0], op[1], im, ra, rb});
        stb_q.push_back('{c + 1, 5'd0, op[0], op[1], im, 3'd0, 3'd0});
        wbq.push_back('{c + 2, rd, res});
        return c + 2 + GAP;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.instr_valid && bus.instr_ready) begin
                if (acc_q.size() == 0) chk("unexpected_accept", 1, 0);
                else chk("accept_cycle", 32'(cyc), 32'(acc_q.pop_front()));
            end
            if (bus.busy && !bus.wb_en) begin
                if (stb_q.size() == 0) chk("unexpected_phase", 32'(bus.reg_en), 0);
                else begin
                    se = stb_q.pop_front();
                    chk("phase_cycle", 32'(cyc), 32'(se.c));
                    chk("phase_ctrl", 32'({bus.reg_en, bus.f_add, bus.f_load, bus.imm, bus.rd_addr_a, bus.rd_addr_b}),
                        32'({se.ren, se.fa, se.fl, se.im, se.ra, se.rb}));
                end
            end else if (bus.wb_en) begin
                if (wbq.size() == 0) chk("unexpected_wb", 1, 0);
                else begin
                    we = wbq.pop_front();
                    chk("wb_cycle", 32'(cyc), 32'(we.c));
                    chk("wb_addr_data", 32'({bus.wb_addr, bus.wb_data}), 32'({we.addr, we.data}));
                    chk("wb_quiet", 32'({bus.reg_en, bus.f_add, bus.f_load, bus.imm, bus.rd_addr_a, bus.rd_addr_b}), 0);
                end
            end else
                chk("idle_quiet", 32'({bus.reg_en, bus.f_add, bus.f_load, bus.imm, bus.rd_addr_a, bus.rd_addr_b, bus.wb_addr}), 0);
        end
    end

    task automatic send(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [2:0] rd, input logic [7:0] im);
        bus.instr_valid = 1;
        bus.instr_op = op;
        bus.instr_ra = ra;
        bus.instr_rb = rb;
        bus.instr_rd = rd;
        bus.instr_imm = im;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.instr_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("send_timeout", 1, 0);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && (bus.busy || acc_q.size() > 0 || stb_q.size() > 0 || wbq.size() > 0); n++)
            @(posedge clk);
        chk("drain_queues", 32'(acc_q.size() + stb_q.size() + wbq.size()), 0);
        @(posedge clk);
        #1;
    endtask

    int t;
    initial begin
        bus.instr_valid = 1;
        bus.instr_op = 3'd1;
        bus.instr_ra = 3'd7;
        bus.instr_rb = 3'd7;
        bus.instr_rd = 3'd7;
        bus.instr_imm = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        bus.instr_valid = 0;
        #1;
        chk("rst_ready", 32'(bus.instr_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_wb", 32'({bus.wb_en, bus.wb_addr, bus.wb_data}), 0);
        repeat (3) @(posedge clk);
        #1;
        t = cyc;
        void'(exp_instr(t, 3'd1, 3'd2, 3'd5, 3'd3, 8'h12, 8'h5A));
        send(3'd1, 3'd2, 3'd5, 3'd3, 8'h12);
        bus.instr_valid = 0;
        drain();
        t = cyc;
        void'(exp_instr(t, 3'd5, 3'd1, 3'd4, 3'd6, 8'h33, 8'hA5));
        send(3'd5, 3'd1, 3'd4, 3'd6, 8'h33);
        bus.instr_valid = 0;
        drain();
        t = cyc;
        void'(exp_instr(t, 3'd2, 3'd6, 3'd0, 3'd1, 8'h80, 8'h01));
        send(3'd2, 3'd6, 3'd0, 3'd1, 8'h80);
        bus.instr_valid = 0;
        drain();
        t = cyc;
        void'(exp_instr(t, 3'd7, 3'd3, 3'd2, 3'd7, 8'hC3, 8'hFE));
        send(3'd7, 3'd3, 3'd2, 3'd7, 8'hC3);
        bus.instr_valid = 0;
        drain();
        t = cyc;
        t = exp_instr(t, 3'd0, 3'd1, 3'd1, 3'd1, 8'h55, 8'h00);
        void'(exp_instr(t, 3'd3, 3'd4, 3'd5, 3'd2, 8'h0F, 8'h3C));
        send(3'd0, 3'd1, 3'd1, 3'd1, 8'h55);
        send(3'd3, 3'd4, 3'd5, 3'd2, 8'h0F);
        bus.instr_valid = 0;
        drain();
        t = cyc;
        t = exp_instr(t, 3'd1, 3'd1, 3'd2, 3'd3, 8'h11, 8'h21);
        t = exp_instr(t, 3'd2, 3'd3, 3'd4, 3'd5, 8'h22, 8'h42);
        void'(exp_instr(t, 3'd3, 3'd5, 3'd6, 3'd7, 8'h33, 8'h63));
        send(3'd1, 3'd1, 3'd2, 3'd3, 8'h11);
        send(3'd2, 3'd3, 3'd4, 3'd5, 8'h22);
        send(3'd3, 3'd5, 3'd6, 3'd7, 8'h33);
        bus.instr_valid = 0;
        drain();
        t = cyc;
        acc_q.push_back(t);
        stb_q.push_back('{t + 1, 5'b00011, 1'b1, 1'b0, 8'h44, 3'd2, 3'd0});
        send(3'd1, 3'd2, 3'd3, 3'd4, 8'h44);
        bus.instr_valid = 0;
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 0);
        chk("rst_mid_ready", 32'(bus.instr_ready), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid_no_wb", 32'(acc_q.size() + stb_q.size() + wbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Issue-side control sequencer for the 8-bit fixed-point ALU datapath. It accepts one instruction per valid/ready handshake and drives the register-file read addresses. It then drives the ALU operand-register load strobes (`reg_en`) and the mux selects (`f_add`, `f_load`, `imm`) in a fixed phase order, captures the ALU `result`, and issues a one-cycle register-file writeback. It sits between instruction fetch/decode and the ALU plus register file, and it is the only block that drives the ALU's control inputs.

## Interface
Parameters:
- `BUS_WIDTH`, 8, width of the datapath, `imm`, `result` and writeback data.
- `REG_ADDR_W`, 3, register-file address width.

Ports:
- `clk`, in, 1, the single clock; all state updates on its rising edge.
- `rst`, in, 1, synchronous active-high reset.
- `instr_valid`, in, 1, an instruction is offered.
- `instr_ready`, out, 1, the sequencer can accept an instruction.
- `instr_op`, in, 3, opcode.
- `instr_ra`, `instr_rb`, `instr_rd`, in, `REG_ADDR_W` each, source A, source B and destination registers.
- `instr_imm`, in, `BUS_WIDTH`, immediate/coefficient.
- `rd_addr_a`, `rd_addr_b`, out, `REG_ADDR_W` each, register-file read addresses (combinational read, data goes straight to the ALU).
- `reg_en`, out, 5, ALU operand-register load enables [a,b,c,d,e] = bits [0..4].
- `f_add`, `f_load`, out, 1 each, ALU mux selects.
- `imm`, out, `BUS_WIDTH`, immediate presented to the ALU.
- `result`, in, `BUS_WIDTH`, ALU combinational result.
- `wb_en`, out, 1, register-file write strobe.
- `wb_addr`, out, `REG_ADDR_W`, write address.
- `wb_data`, out, `BUS_WIDTH`, write data.
- `busy`, out, 1, the sequencer is in any state other than IDLE.

## Operation
- States: IDLE, LD1, LD2, EXEC, WB.
- Decode of `instr_op`:
  - `op == 3'd0` is NOP.
  - Otherwise `f_add = op[0]`, `f_load = op[1]`, and `keep = op[2]`, which skips LD1 and reuses the ALU's previous a/b operands.
- IDLE:
  - `instr_ready = 1`.
  - On `instr_valid && instr_ready` the sequencer latches op, ra, rb, rd and imm.
  - A non-NOP goes to LD1, or to LD2 if keep is set.
  - A NOP is consumed and the sequencer stays in IDLE, with no strobes and no writeback.
- LD1: `rd_addr_a = ra`, `reg_en = 5'b00011`, then go to LD2.
- LD2: `rd_addr_a = ra`, `rd_addr_b = rb`, `reg_en = 5'b11100`, then go to EXEC.
- EXEC:
  - `reg_en = 0`.
  - `result` is sampled into the writeback data register at the end of the cycle.
  - Go to WB.
- WB: `wb_en = 1`, `wb_addr = rd`, then go to IDLE.
- `f_add`, `f_load` and `imm` are held at the latched values from LD1 through EXEC, and are 0 in IDLE and WB.
- `rd_addr_*` are 0 outside the states that drive them.
- Reset values:
  - state is IDLE.
  - `reg_en`, `wb_en`, `f_add`, `f_load`, `imm`, `wb_addr`, `wb_data`, `rd_addr_a`, `rd_addr_b` and `busy` are all 0.
  - `instr_ready` is 1 from the first cycle after reset.
- Reset mid-operation: the latched instruction is discarded, no further `reg_en` or `wb_en` pulses occur, and the ALU operand registers are left as they are (they are not owned by this block).
- `instr_valid` while busy is ignored: the instruction is neither accepted nor lost, and the producer must hold it.
- `result` is treated as opaque; no arithmetic is performed in this block.

## Timing
- Full instruction: handshake in cycle 0, LD1 in cycle 1, LD2 in cycle 2, EXEC in cycle 3, WB in cycle 4. The next acceptance is possible in cycle 5, giving a throughput of 1 instruction per 5 cycles.
- keep instruction: 4 cycles.
- NOP: 1 cycle.
- `wb_en` is a single-cycle pulse. `wb_data` equals `result` as it was during EXEC.
- Read-after-write is safe: the register file commits at the end of WB, and the earliest read of the next instruction is in LD1 or LD2, which comes after that.

## Configuration
- `ALU_SEQ_OVERLAP_EN` defined:
  - `instr_ready` is also 1 in WB, and a handshake there moves the sequencer directly to LD1/LD2 (or to IDLE for a NOP).
  - Throughput improves to 1 instruction per 4 cycles (full) and 1 per 3 (keep).
  - Read-after-write is handled by forwarding: a next-instruction read of `rd` during its first load cycle is still correct, because the register file is write-first. This is a register-file requirement, documented there.
- `ALU_SEQ_OVERLAP_EN` undefined: `instr_ready` is 1 only in IDLE.

## Structure
- The shared package (`alu_seq_pkg`) holds:
  - the state enum `seq_state_t`;
  - the opcode constant `OP_NOP`;
  - the `reg_en` constants `REN_PHASE1 = 5'b00011` and `REN_PHASE2 = 5'b11100`;
  - a decoded-instruction struct carrying f_add, f_load, keep, ra, rb, rd and imm.
- One sub-module, `alu_seq_decode`, holds the combinational opcode-to-struct decode. The FSM and output registers stay in `alu_seq`.

## Test plan
- Reset: assert `rst` for 2 cycles with `instr_valid = 1` -> all outputs 0, `instr_ready = 1`, and no handshake is taken during reset.
- Full op: `op = 3'd1`, `ra = 2`, `rb = 5`, `rd = 3`, `imm = 8'h12`, with the bench driving `result = 8'h5A` in EXEC:
  - `reg_en` sequence is 00011, 11100, 0.
  - `f_add = 1` and `imm = 8'h12` for 3 cycles.
  - `wb_en` pulses in cycle 4 with `wb_addr = 3`, `wb_data = 8'h5A`.
- keep op: `op = 3'd5` -> no 00011 phase, `wb_en` in cycle 3, `busy` for 3 cycles.
- Back-to-back: `instr_valid` held high with 3 instructions -> acceptances at cycles 0, 5 and 10, or 0, 4 and 8 with `ALU_SEQ_OVERLAP_EN`, and none dropped.
- NOP: `op = 0` -> accepted in 1 cycle, `reg_en` and `wb_en` stay 0.
- Reset during LD2 -> the next cycle is IDLE, and no EXEC or WB follows.
